// File: rtl/io_input_ctrl.sv
// Operator input sequencer: stalls the core on IN, waits for a fresh confirm press,
// samples the switches and answers with a four-phase req/ack. IO_INPUT_TIMEOUT_EN adds a press timeout.
module io_input_ctrl #(
  parameter int unsigned SW_W     = 16,
  parameter bit          SIGN_EXT = 1'b0,
  parameter logic [31:0] TIMEOUT  = 32'd100000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_req,
  input  logic            confirm,
  input  logic [SW_W-1:0] switches,
  output logic [31:0]     in_data,
  output logic            in_ack,
  output logic            halt,
  output logic            waiting,
  output logic            timed_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_PRESS,
    S_CAPTURE,
    S_ACK
  } state_t;

  state_t          state_q, state_d;
  logic            conf_q;
  logic [SW_W-1:0] sample_q, sample_d;
  logic [31:0]     in_data_q, in_data_d;
  logic [31:0]     ext_w;
  logic            conf_rise;

  assign conf_rise = confirm & ~conf_q;

  if (SW_W == 32) begin : g_full_width
    assign ext_w = sample_q;
  end else if (SIGN_EXT) begin : g_sign_ext
    assign ext_w = {{(32-SW_W){sample_q[SW_W-1]}}, sample_q};
  end else begin : g_zero_ext
    assign ext_w = {{(32-SW_W){1'b0}}, sample_q};
  end

`ifdef IO_INPUT_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        to_pend_q, to_pend_d;
  logic        timed_out_q, timed_out_d;
  logic        expired;

  assign expired = (cnt_q == TIMEOUT - 32'd1);
`endif

  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    in_data_d = in_data_q;
`ifdef IO_INPUT_TIMEOUT_EN
    cnt_d       = cnt_q;
    to_pend_d   = to_pend_q;
    timed_out_d = timed_out_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_req) begin
          state_d = S_ARM;
`ifdef IO_INPUT_TIMEOUT_EN
          cnt_d       = '0;
          to_pend_d   = 1'b0;
          timed_out_d = 1'b0;
`endif
        end
      end
      S_ARM: begin
        // A press already held at request time must be released first.
        if (!in_req) begin
          state_d = S_IDLE;
`ifdef IO_INPUT_TIMEOUT_EN
        end else if (expired) begin
          state_d   = S_CAPTURE;
          sample_d  = '0;
          to_pend_d = 1'b1;
`endif
        end else if (!conf_q) begin
          state_d = S_WAIT_PRESS;
        end
`ifdef IO_INPUT_TIMEOUT_EN
        cnt_d = cnt_q + 32'd1;
`endif
      end
      S_WAIT_PRESS: begin
        if (!in_req) begin
          state_d = S_IDLE;
        end else if (conf_rise) begin
          state_d  = S_CAPTURE;
          sample_d = switches;
`ifdef IO_INPUT_TIMEOUT_EN
        end else if (expired) begin
          state_d   = S_CAPTURE;
          sample_d  = '0;
          to_pend_d = 1'b1;
`endif
        end
`ifdef IO_INPUT_TIMEOUT_EN
        cnt_d = cnt_q + 32'd1;
`endif
      end
      S_CAPTURE: begin
        if (!in_req) begin
          state_d = S_IDLE;
        end else begin
          state_d   = S_ACK;
          in_data_d = ext_w;
`ifdef IO_INPUT_TIMEOUT_EN
          timed_out_d = to_pend_q;
`endif
        end
      end
      S_ACK: begin
        if (!in_req) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      conf_q    <= 1'b0;
      sample_q  <= '0;
      in_data_q <= '0;
    end else begin
      state_q   <= state_d;
      conf_q    <= confirm;
      sample_q  <= sample_d;
      in_data_q <= in_data_d;
    end
  end

`ifdef IO_INPUT_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      to_pend_q   <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      to_pend_q   <= to_pend_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign timed_out = timed_out_q;
`else
  assign timed_out = 1'b0;
`endif

  // Outputs decode straight from state so reset clears them without waiting for a clock.
  assign in_data = in_data_q;
  assign in_ack  = (state_q == S_ACK);
  assign halt    = (state_q == S_ARM) || (state_q == S_WAIT_PRESS) || (state_q == S_CAPTURE);
  assign waiting = (state_q == S_ARM) || (state_q == S_WAIT_PRESS);

endmodule

// File: tb/tb_io_input_ctrl.sv
// Bench for io_input_ctrl: zero- and sign-extending instances share stimulus and are
// checked against words computed by plain integer casts of the switch value at the press.
module tb_io_input_ctrl;
  localparam int SW_W = 16;

  logic            clk = 1'b0;
  logic            rst_n, in_req, confirm;
  logic [SW_W-1:0] switches;
  logic [31:0]     data_z, data_s;
  logic            ack_z, ack_s, halt_z, halt_s, wait_z, wait_s, to_z, to_s;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_z, model_s;

  always #5 clk = ~clk;

  io_input_ctrl #(.SW_W(SW_W), .SIGN_EXT(1'b0), .TIMEOUT(32'd20)) dut_z (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .confirm(confirm), .switches(switches),
    .in_data(data_z), .in_ack(ack_z), .halt(halt_z), .waiting(wait_z), .timed_out(to_z)
  );

  io_input_ctrl #(.SW_W(SW_W), .SIGN_EXT(1'b1), .TIMEOUT(32'd20)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .confirm(confirm), .switches(switches),
    .in_data(data_s), .in_ack(ack_s), .halt(halt_s), .waiting(wait_s), .timed_out(to_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request, wait pre cycles in the stall, press once with sw, then complete the handshake.
  task automatic test_transfer(input string name, input logic [SW_W-1:0] sw, input int pre,
                               input bit keep_conf);
    in_req   = 1'b1;
    switches = SW_W'($urandom);
    tick();
    checks++;
    if ({halt_z, halt_s, wait_z, wait_s} !== 4'hF) begin
      errors++;
      $display("FAIL %s stall_on_request: got halt/wait=%b required 1111", name,
               {halt_z, halt_s, wait_z, wait_s});
    end
    repeat (pre) begin
      switches = SW_W'($urandom);
      tick();
    end
    checks++;
    if ({ack_z, ack_s, halt_z, halt_s} !== 4'b0011) begin
      errors++;
      $display("FAIL %s waiting_state: got ack/halt=%b required 0011", name,
               {ack_z, ack_s, halt_z, halt_s});
    end
    switches = sw;
    confirm  = 1'b1;
    tick();
    switches = ~sw;
    checks++;
    if ({ack_z, ack_s} !== 2'b00) begin
      errors++;
      $display("FAIL %s early_ack: got ack=%b required 00", name, {ack_z, ack_s});
    end
    tick();
    model_z = 32'(sw);
    model_s = 32'($signed(sw));
    checks++;
    if ({ack_z, ack_s, halt_z, halt_s, wait_z, wait_s} !== 6'b110000) begin
      errors++;
      $display("FAIL %s ack_latency: got ack/halt/wait=%b required 110000", name,
               {ack_z, ack_s, halt_z, halt_s, wait_z, wait_s});
    end
    checks++;
    if (data_z !== model_z) begin
      errors++;
      $display("FAIL %s data_zext: got %h required %h", name, data_z, model_z);
    end
    checks++;
    if (data_s !== model_s) begin
      errors++;
      $display("FAIL %s data_sext: got %h required %h", name, data_s, model_s);
    end
    checks++;
    if ({to_z, to_s} !== 2'b00) begin
      errors++;
      $display("FAIL %s timed_out: got %b required 00", name, {to_z, to_s});
    end
    if (!keep_conf) begin
      // Confirm activity while acknowledged must be ignored.
      confirm = 1'b0;
      tick();
      confirm = 1'b1;
      tick();
      confirm = 1'b0;
    end
    tick();
    checks++;
    if ({ack_z, ack_s} !== 2'b11 || data_z !== model_z || data_s !== model_s) begin
      errors++;
      $display("FAIL %s ack_hold: got ack=%b data=%h/%h required 11 %h/%h", name,
               {ack_z, ack_s}, data_z, data_s, model_z, model_s);
    end
    in_req = 1'b0;
    tick();
    checks++;
    if ({ack_z, ack_s, halt_z, halt_s} !== 4'b0000 || data_z !== model_z || data_s !== model_s) begin
      errors++;
      $display("FAIL %s ack_release: got ack/halt=%b data=%h/%h required 0000 %h/%h", name,
               {ack_z, ack_s, halt_z, halt_s}, data_z, data_s, model_z, model_s);
    end
    $display("xfer %s sw=%h zext=%h sext=%h", name, sw, data_z, data_s);
  endtask

  task automatic test_reset();
    checks++;
    if ({ack_z, ack_s, halt_z, halt_s, wait_z, wait_s, to_z, to_s} !== 8'h00 ||
        data_z !== 32'h0 || data_s !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got flags=%b data=%h/%h required 0 0/0",
               {ack_z, ack_s, halt_z, halt_s, wait_z, wait_s, to_z, to_s}, data_z, data_s);
    end
    $display("xfer reset flags=%b", {ack_z, ack_s, halt_z, halt_s, wait_z, wait_s, to_z, to_s});
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      test_transfer("random", SW_W'($urandom), int'($urandom_range(2, 8)), 1'b0);
    end
  endtask

  task automatic test_stale_press();
    confirm = 1'b1;
    tick();
    in_req   = 1'b1;
    switches = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({ack_z, ack_s, wait_z, wait_s} !== 4'b0011) begin
        errors++;
        $display("FAIL stale_press cycle %0d: got ack/wait=%b required 0011", i,
                 {ack_z, ack_s, wait_z, wait_s});
      end
    end
    confirm = 1'b0;
    test_transfer("stale", 16'h0003, 2, 1'b0);
  endtask

  task automatic test_abort();
    in_req = 1'b1;
    repeat (4) tick();
    in_req = 1'b0;
    tick();
    checks++;
    if ({ack_z, ack_s, halt_z, halt_s, wait_z, wait_s} !== 6'b0 ||
        data_z !== model_z || data_s !== model_s) begin
      errors++;
      $display("FAIL abort: got flags=%b data=%h/%h required 000000 %h/%h",
               {ack_z, ack_s, halt_z, halt_s, wait_z, wait_s}, data_z, data_s, model_z, model_s);
    end
    confirm = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({ack_z, ack_s, halt_z, halt_s} !== 4'b0) begin
        errors++;
        $display("FAIL idle_press cycle %0d: got ack/halt=%b required 0000", i,
                 {ack_z, ack_s, halt_z, halt_s});
      end
    end
    confirm = 1'b0;
    tick();
    $display("xfer abort data=%h/%h", data_z, data_s);
  endtask

  task automatic test_reset_mid();
    in_req = 1'b1;
    repeat (4) tick();
    checks++;
    if ({wait_z, wait_s} !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_setup: got waiting=%b required 11", {wait_z, wait_s});
    end
    rst_n = 1'b0;
    #1;
    model_z = 32'h0;
    model_s = 32'h0;
    checks++;
    if ({ack_z, ack_s, halt_z, halt_s, wait_z, wait_s, to_z, to_s} !== 8'h00 ||
        data_z !== 32'h0 || data_s !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got flags=%b data=%h/%h required 0 0/0",
               {ack_z, ack_s, halt_z, halt_s, wait_z, wait_s, to_z, to_s}, data_z, data_s);
    end
    in_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    $display("xfer reset_mid flags=%b", {ack_z, ack_s, halt_z, halt_s});
  endtask

  task automatic test_back_to_back();
    test_transfer("b2b_first", 16'h0011, 3, 1'b1);
    in_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({ack_z, ack_s} !== 2'b00) begin
        errors++;
        $display("FAIL b2b_single_press cycle %0d: got ack=%b required 00", i, {ack_z, ack_s});
      end
    end
    confirm = 1'b0;
    test_transfer("b2b_second", 16'h0022, 3, 1'b0);
  endtask

`ifdef IO_INPUT_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    in_req = 1'b1;
    tick();
    n = 0;
    while (!ack_z && n < 40) begin
      tick();
      n++;
    end
    model_z = 32'h0;
    model_s = 32'h0;
    checks++;
    if (n < 20 || n > 21 || {ack_z, ack_s} !== 2'b11) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles ack=%b required 20..21 11", n, {ack_z, ack_s});
    end
    checks++;
    if (data_z !== 32'h0 || data_s !== 32'h0 || {to_z, to_s} !== 2'b11) begin
      errors++;
      $display("FAIL timeout_word: got data=%h/%h to=%b required 0/0 11", data_z, data_s, {to_z, to_s});
    end
    in_req = 1'b0;
    tick();
    checks++;
    if ({to_z, to_s} !== 2'b11 || {ack_z, ack_s} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_sticky: got to/ack=%b required 1100", {to_z, to_s, ack_z, ack_s});
    end
    in_req = 1'b1;
    tick();
    checks++;
    if ({to_z, to_s} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_clear: got to=%b required 00", {to_z, to_s});
    end
    $display("xfer timeout cycles=%0d", n);
    test_transfer("after_timeout", 16'h1234, 2, 1'b0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_req   = 1'b0;
    confirm  = 1'b0;
    switches = '0;
    model_z  = 32'h0;
    model_s  = 32'h0;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_transfer("basic", 16'h00A5, 10, 1'b0);
    test_transfer("sign_ext", 16'h8001, 4, 1'b0);
    test_random();
    test_stale_press();
    test_abort();
    test_reset_mid();
    test_back_to_back();
`ifdef IO_INPUT_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_input_ctrl.md
Name: io_input_ctrl

Overview:
- Sequences the processor's IN instruction against the operator confirm button.
- On request: stalls the core, waits for a fresh debounced press, samples the switch bank, returns the word through a four-phase req/ack handshake, then releases the stall.
- Sits between the core's I/O decode and the button debouncer output plus the board switches.

Parameters:
- SW_W, 16, switch bank width (1..32)
- SIGN_EXT, 0, 1 = sign-extend switch value to 32 bits; 0 = zero-extend
- TIMEOUT, 32'd100000000, cycles to wait for a press before timing out (used only with the optional feature)

Ports:
- clk  input  1  system clock, all state on posedge
- rst_n  input  1  asynchronous active-low reset
- in_req  input  1  core requests input word; held until in_ack seen
- confirm  input  1  debounced button level from the debouncer; may stay high for several cycles
- switches  input  SW_W  raw switch bank
- in_data  output  32  captured word; valid while in_ack=1
- in_ack  output  1  handshake acknowledge
- halt  output  1  stall to core
- waiting  output  1  LED: waiting for operator press
- timed_out  output  1  sticky flag for last transfer (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_data=0, in_ack=0, halt=0, waiting=0, timed_out=0, sample register and timeout counter cleared.
- confirm is registered once internally (conf_q). Rising edge = confirm & ~conf_q, so one press yields one event regardless of pulse length.
- States:
  - IDLE: in_req=1 -> ARM, halt=1 next cycle. Otherwise stay.
  - ARM: wait for conf_q=0, so a press already in progress at request time is not consumed. When low -> WAIT_PRESS. waiting=1.
  - WAIT_PRESS: waiting=1, halt=1. On rising edge, latch switches into the sample register -> CAPTURE.
  - CAPTURE: form in_data = extend(sample) per SIGN_EXT, in_ack=1 -> ACK. Latency from press edge to in_ack = 2 cycles.
  - ACK: in_ack and in_data held. halt=0 from entry into ACK. When in_req=0: in_ack=0 next cycle -> IDLE. in_data keeps its value until the next capture.
- halt=1 in ARM, WAIT_PRESS, CAPTURE; 0 elsewhere. waiting=1 in ARM and WAIT_PRESS only.
- in_req dropping before ACK (aborted instruction): return to IDLE next cycle; halt=0, in_ack stays 0, in_data unchanged.
- confirm activity in IDLE or ACK is ignored.
- A new in_req is accepted only after in_ack has returned to 0. Back-to-back requests each require a separate press.
- Switch values that change while waiting have no effect; only the value at the capture edge is used.
- Reset mid-operation: immediate return to reset values; no in_ack is produced for the interrupted request.
- Width rule: SW_W=32 passes through unchanged. For SW_W<32, bits [31:SW_W] are 0 or a replica of switches[SW_W-1].

Optional Feature:
- Macro: IO_INPUT_TIMEOUT_EN.
- When defined:
  - A 32-bit counter runs in ARM and WAIT_PRESS.
  - Reaching TIMEOUT-1 without a rising edge -> CAPTURE with in_data=0 and timed_out=1.
  - timed_out clears on the next accepted request (IDLE->ARM).
- When undefined: no counter, wait is unbounded, timed_out tied 0.

Test Plan:
- Basic transfer:
  - Stimulus: SW_W=16, SIGN_EXT=0, switches=16'h00A5; assert in_req; after 10 cycles pulse confirm high for 3 cycles.
  - Response: in_ack=1 exactly 2 cycles after the confirm rise; in_data=32'h000000A5; halt falls with in_ack; in_ack drops 1 cycle after in_req drops.
- Sign extension:
  - Stimulus: SIGN_EXT=1, switches=16'h8001, one press.
  - Response: in_data=32'hFFFF8001.
- Stale press:
  - Stimulus: confirm already high when in_req rises; hold it 5 cycles, release, press again with switches=16'h0003.
  - Response: no capture on the first press; capture on the second; in_data=32'h3.
- Abort and reset:
  - Stimulus: drop in_req while in WAIT_PRESS.
  - Response: halt=0 next cycle, in_ack never asserts.
  - Stimulus: rst_n low mid-WAIT_PRESS.
  - Response: all outputs 0 immediately.
- Back-to-back:
  - Stimulus: two requests, each with one press, switches=16'h0011 then 16'h0022.
  - Response: two acks carrying 32'h11 then 32'h22; a single press never satisfies both requests.
- Timeout (IO_INPUT_TIMEOUT_EN defined, TIMEOUT=20):
  - Stimulus: request with no press.
  - Response: in_ack at cycle 20 after ARM entry (±1 for CAPTURE); in_data=0; timed_out=1; timed_out clears on the next request.
